// File: rtl/pipe_pkg.sv
// Shared encodings for pipeline stages: write-data select codes and the
// occupancy state of a two-entry skid stage.
package pipe_pkg;

   localparam logic [1:0] WSEL_DATA = 2'd0;
   localparam logic [1:0] WSEL_ALT  = 2'd1;
   localparam logic [1:0] WSEL_PC8  = 2'd2;
   localparam logic [1:0] WSEL_ZERO = 2'd3;

   // State codes equal the number of held entries, so the state register
   // can be presented directly as the occupancy count.
   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   // Link address of a branch-and-link: two instructions past the PC.
   function automatic logic [31:0] pc_plus8(input logic [31:0] pc);
      return pc + 32'd8;
   endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Handshake and payload bundle of one pipeline stage (upstream, downstream,
// forwarding tap and occupancy).
//
// Handshake: a transfer happens at posedge clk when valid && ready are both 1.
// A producer holding valid keeps its payload stable until the transfer; the
// stage's in_ready is a register, so it never depends on out_ready in the
// same cycle.
interface pipe_stage_skid_if #(
   parameter int DW = 32,
   parameter int AW = 5
);

   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   in_pc;
   logic [DW-1:0] in_data;
   logic [DW-1:0] in_alt;
   logic [1:0]    in_wsel;
   logic [AW-1:0] in_waddr;
   logic          in_we;

   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_pc;
   logic [DW-1:0] out_data;
   logic [DW-1:0] out_alt;
   logic [AW-1:0] out_waddr;
   logic          out_we;

   logic [DW-1:0] fwd_data;
   logic          fwd_valid;
   logic [1:0]    count;

   // Environment side: drives upstream entries and downstream ready.
   modport master (
      output flush, in_valid, in_pc, in_data, in_alt, in_wsel, in_waddr, in_we,
      output out_ready,
      input  in_ready,
      input  out_valid, out_pc, out_data, out_alt, out_waddr, out_we,
      input  fwd_data, fwd_valid, count
   );

   // Stage side.
   modport slave (
      input  flush, in_valid, in_pc, in_data, in_alt, in_wsel, in_waddr, in_we,
      input  out_ready,
      output in_ready,
      output out_valid, out_pc, out_data, out_alt, out_waddr, out_we,
      output fwd_data, fwd_valid, count
   );

endinterface

// File: rtl/wdata_sel.sv
// Register write-data select: picks ALU result, alternate result, PC+8 or
// zero. Purely combinational so any stage can drop it onto its head entry.
module wdata_sel
   import pipe_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic [1:0]    wsel,
   input  logic [DW-1:0] data,
   input  logic [DW-1:0] alt,
   input  logic [31:0]   pc,
   output logic [DW-1:0] wdata
);

   logic [31:0]   pc8;
   logic [DW-1:0] pc8_fit;

   assign pc8 = pc_plus8(pc);

   // The link address is 32 bits; fit it to the datapath width.
   generate
      if (DW > 32) begin : g_pc8_wide
         assign pc8_fit = {{(DW-32){1'b0}}, pc8};
      end else if (DW == 32) begin : g_pc8_same
         assign pc8_fit = pc8;
      end else begin : g_pc8_narrow
         assign pc8_fit = pc8[DW-1:0];
      end
   endgenerate

   always_comb begin
      wdata = '0;
      case (wsel)
         WSEL_DATA: wdata = data;
         WSEL_ALT:  wdata = alt;
         WSEL_PC8:  wdata = pc8_fit;
         WSEL_ZERO: wdata = '0;
         default:   wdata = '0;
      endcase
   end

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry skid pipeline stage (main + skid, FIFO order, head = main) with a
// registered in_ready and a forwarding tap on the head entry.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input logic              clk,
   input logic              reset,
   pipe_stage_skid_if.slave bus
);

   typedef struct packed {
      logic [31:0]   pc;
      logic [DW-1:0] data;
      logic [DW-1:0] alt;
      logic [1:0]    wsel;
      logic [AW-1:0] waddr;
      logic          we;
   } entry_t;

   entry_t        main_q;
   entry_t        skid_q;
   entry_t        in_entry;
   logic [1:0]    state_q;
   logic [1:0]    state_d;
   logic          in_ready_q;
   logic          accept;
   logic          emit;
   logic          head_valid;
   logic          load_main_in;
   logic          load_main_skid;
   logic          load_skid_in;
   logic [DW-1:0] head_wdata;

   assign in_entry = '{
      pc:    bus.in_pc,
      data:  bus.in_data,
      alt:   bus.in_alt,
      wsel:  bus.in_wsel,
      waddr: bus.in_waddr,
      we:    bus.in_we
   };

   assign head_valid = (state_q == ST_ONE) || (state_q == ST_FULL);
   assign accept     = bus.in_valid && in_ready_q;
   assign emit       = head_valid && bus.out_ready;

   always_comb begin
      state_d        = state_q;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid_in   = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               state_d      = ST_ONE;
               load_main_in = 1'b1;
            end
         end
         ST_ONE: begin
            if (accept && emit) begin
               load_main_in = 1'b1;
            end else if (accept) begin
               state_d      = ST_FULL;
               load_skid_in = 1'b1;
            end else if (emit) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            // in_ready is low here, so only the drain path exists.
            if (emit) begin
               state_d        = ST_ONE;
               load_main_skid = 1'b1;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   // Flush only resets occupancy; payload stays so idle outputs hold.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_EMPTY;
         in_ready_q <= 1'b1;
         main_q     <= '0;
         skid_q     <= '0;
      end else if (bus.flush) begin
         state_q    <= ST_EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != ST_FULL);
         if (load_main_in) begin
            main_q <= in_entry;
         end else if (load_main_skid) begin
            main_q <= skid_q;
         end
         if (load_skid_in) begin
            skid_q <= in_entry;
         end
      end
   end

   wdata_sel #(.DW(DW)) u_wdata_sel (
      .wsel  (main_q.wsel),
      .data  (main_q.data),
      .alt   (main_q.alt),
      .pc    (main_q.pc),
      .wdata (head_wdata)
   );

   assign bus.in_ready  = in_ready_q;
   assign bus.count     = state_q;
   assign bus.out_valid = head_valid;
   assign bus.out_pc    = main_q.pc;
   assign bus.out_data  = main_q.data;
   assign bus.out_alt   = main_q.alt;
   assign bus.out_waddr = main_q.waddr;
   assign bus.out_we    = head_valid && main_q.we;
   assign bus.fwd_data  = head_wdata;
   assign bus.fwd_valid = head_valid && main_q.we && (main_q.waddr != '0);

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: a hand-computed vector table, then a
// streaming sequence checked against an expected-PC queue.
module tb_pipe_stage_skid;
   import pipe_pkg::*;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NV = 17;

   logic clk;
   logic reset;

   pipe_stage_skid_if #(.DW(DW), .AW(AW)) bus ();

   pipe_stage_skid #(.DW(DW), .AW(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   // ---------------- clock / watchdog ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "watchdog");
   end

   // ---------------- vector table ----------------
   typedef struct {
      logic        rst;
      logic        fl;
      logic        iv;
      logic [31:0] pc;
      logic [31:0] data;
      logic [31:0] alt;
      logic [1:0]  wsel;
      logic [4:0]  waddr;
      logic        we;
      logic        ordy;
      logic [1:0]  e_cnt;
      logic        e_ov;
      logic        e_ir;
      logic [31:0] e_pc;
      logic [31:0] e_fwd;
      logic        e_fv;
      logic        e_we;
   } vec_t;

   vec_t vecs[NV];

   int n_cmp;
   int n_err;
   logic [31:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic rst, input logic fl, input logic iv,
                        input logic [31:0] pc, input logic [31:0] data,
                        input logic [31:0] alt, input logic [1:0] wsel,
                        input logic [4:0] waddr, input logic we, input logic ordy);
      reset        = rst;
      bus.flush    = fl;
      bus.in_valid = iv;
      bus.in_pc    = pc;
      bus.in_data  = data;
      bus.in_alt   = alt;
      bus.in_wsel  = wsel;
      bus.in_waddr = waddr;
      bus.in_we    = we;
      bus.out_ready = ordy;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, WSEL_DATA, 5'd0, 1'b0, 1'b0);

      //           rst fl iv  pc            data       alt        wsel       waddr we ordy  cnt ov ir  e_pc          e_fwd      fv we
      vecs[0]  = '{1, 0, 0, 32'h0,        32'h0,     32'h0,     WSEL_DATA, 0, 0, 0,   0, 0, 1, 32'h0,        32'h0,     0, 0};
      vecs[1]  = '{0, 0, 1, 32'h3000,     32'h12,    32'h0,     WSEL_DATA, 3, 1, 0,   1, 1, 1, 32'h3000,     32'h12,    1, 1};
      vecs[2]  = '{0, 0, 1, 32'h3004,     32'h22,    32'h0,     WSEL_DATA, 4, 1, 0,   2, 1, 0, 32'h3000,     32'h12,    1, 1};
      vecs[3]  = '{0, 0, 1, 32'h3008,     32'h33,    32'h0,     WSEL_DATA, 6, 1, 0,   2, 1, 0, 32'h3000,     32'h12,    1, 1};
      vecs[4]  = '{0, 0, 1, 32'h3008,     32'h33,    32'h0,     WSEL_DATA, 6, 1, 1,   1, 1, 1, 32'h3004,     32'h22,    1, 1};
      vecs[5]  = '{0, 0, 1, 32'h3008,     32'h33,    32'h0,     WSEL_DATA, 6, 1, 0,   2, 1, 0, 32'h3004,     32'h22,    1, 1};
      vecs[6]  = '{0, 0, 0, 32'h0,        32'h0,     32'h0,     WSEL_DATA, 0, 0, 1,   1, 1, 1, 32'h3008,     32'h33,    1, 1};
      vecs[7]  = '{0, 0, 0, 32'h0,        32'h0,     32'h0,     WSEL_DATA, 0, 0, 1,   0, 0, 1, 32'h3008,     32'h33,    0, 0};
      vecs[8]  = '{0, 0, 1, 32'hFFFFFFFC, 32'h55,    32'h0,     WSEL_PC8,  0, 1, 0,   1, 1, 1, 32'hFFFFFFFC, 32'h4,     0, 1};
      vecs[9]  = '{0, 0, 1, 32'h4000,     32'h99,    32'hABCD,  WSEL_ALT,  5, 1, 1,   1, 1, 1, 32'h4000,     32'hABCD,  1, 1};
      vecs[10] = '{0, 0, 1, 32'h4004,     32'h77,    32'h11,    WSEL_ZERO, 7, 1, 1,   1, 1, 1, 32'h4004,     32'h0,     1, 1};
      vecs[11] = '{0, 0, 1, 32'h4008,     32'h88,    32'h0,     WSEL_DATA, 8, 0, 0,   2, 1, 0, 32'h4004,     32'h0,     1, 1};
      vecs[12] = '{0, 1, 1, 32'h5000,     32'h50,    32'h0,     WSEL_DATA, 9, 1, 1,   0, 0, 1, 32'h4004,     32'h0,     0, 0};
      vecs[13] = '{0, 0, 0, 32'h0,        32'h0,     32'h0,     WSEL_DATA, 0, 0, 1,   0, 0, 1, 32'h4004,     32'h0,     0, 0};
      vecs[14] = '{0, 0, 1, 32'h6000,     32'h66,    32'h0,     WSEL_DATA, 9, 1, 1,   1, 1, 1, 32'h6000,     32'h66,    1, 1};
      vecs[15] = '{0, 0, 1, 32'h6004,     32'h67,    32'h0,     WSEL_DATA, 9, 1, 0,   2, 1, 0, 32'h6000,     32'h66,    1, 1};
      vecs[16] = '{1, 1, 1, 32'h7777,     32'h1,     32'h0,     WSEL_DATA, 9, 1, 1,   0, 0, 1, 32'h0,        32'h0,     0, 0};

      step();
      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].pc, vecs[i].data,
               vecs[i].alt, vecs[i].wsel, vecs[i].waddr, vecs[i].we, vecs[i].ordy);
         step();
         check($sformatf("v%0d count", i),     {30'd0, bus.count},     {30'd0, vecs[i].e_cnt});
         check($sformatf("v%0d out_valid", i), {31'd0, bus.out_valid}, {31'd0, vecs[i].e_ov});
         check($sformatf("v%0d in_ready", i),  {31'd0, bus.in_ready},  {31'd0, vecs[i].e_ir});
         check($sformatf("v%0d out_pc", i),    bus.out_pc,             vecs[i].e_pc);
         check($sformatf("v%0d fwd_data", i),  bus.fwd_data,           vecs[i].e_fwd);
         check($sformatf("v%0d fwd_valid", i), {31'd0, bus.fwd_valid}, {31'd0, vecs[i].e_fv});
         check($sformatf("v%0d out_we", i),    {31'd0, bus.out_we},    {31'd0, vecs[i].e_we});
      end

      // ---------------- streaming: ONE with accept+emit every cycle ----------------
      drive(1'b0, 1'b0, 1'b1, 32'h8000, 32'h80, 32'h0, WSEL_DATA, 5'd1, 1'b1, 1'b0);
      exp_q.push_back(32'h8000);
      step();
      check("stream prime count", {30'd0, bus.count}, 32'd1);
      for (int i = 0; i < 10; i++) begin
         logic [31:0] npc;
         logic [31:0] head;
         npc = 32'h8004 + 32'(i) * 32'd4;
         head = exp_q.pop_front();
         check($sformatf("stream%0d head_pc", i), bus.out_pc, head);
         drive(1'b0, 1'b0, 1'b1, npc, npc + 32'd1, 32'h0, WSEL_DATA, 5'd1, 1'b1, 1'b1);
         exp_q.push_back(npc);
         step();
         check($sformatf("stream%0d count", i), {30'd0, bus.count}, 32'd1);
         check($sformatf("stream%0d fwd_data", i), bus.fwd_data, npc + 32'd1);
      end
      check("stream tail pc", bus.out_pc, exp_q.pop_front());
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, WSEL_DATA, 5'd0, 1'b0, 1'b1);
      step();
      check("stream drain count", {30'd0, bus.count}, 32'd0);
      check("stream drain out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("stream queue empty", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL have parameter DW, default 32, payload/alt data width.
REQ-002 SHALL have parameter AW, default 5, destination register address width.
REQ-003 SHALL have ports: clk  input  1  clock; reset  input  1  reset, synchronous, active-high (clock clk).
REQ-004 SHALL have ports: flush  input  1  discard all held entries; in_valid  input  1  upstream entry valid; in_ready  output  1  stage can accept.
REQ-005 SHALL have ports: in_pc  input  32  instruction PC; in_data  input  DW  ALU result; in_alt  input  DW  HI/LO or shift result; in_wsel  input  2  write-data select.
REQ-006 SHALL have ports: in_waddr  input  AW  destination register; in_we  input  1  register write enable.
REQ-007 SHALL have ports: out_valid  output  1; out_ready  input  1; out_pc  output  32; out_data  output  DW; out_alt  output  DW; out_waddr  output  AW; out_we  output  1.
REQ-008 SHALL have ports: fwd_data  output  DW  forwarding write data of head entry; fwd_valid  output  1  head entry forwardable; count  output  2  occupancy.

Function
REQ-009 SHALL hold up to two entries (main, skid) in FIFO order; head is always main.
REQ-010 SHALL accept on in_valid&&in_ready and emit on out_valid&&out_ready, both at posedge clk.
REQ-011 SHALL use states EMPTY(count 0), ONE(1), FULL(2); out_valid=1 in ONE and FULL.
REQ-012 SHALL drive in_ready as a registered signal, 1 in EMPTY/ONE, 0 in FULL; no combinational path out_ready->in_ready.
REQ-013 EMPTY: accept -> ONE, entry visible on out_* next cycle (latency 1).
REQ-014 ONE: accept only -> FULL (new entry to skid); emit only -> EMPTY; accept+emit -> ONE, new entry to main.
REQ-015 FULL: emit -> ONE, skid moves to main; no emit -> FULL, outputs stable.
REQ-016 SHALL select fwd_data from head: wsel 0 -> out_data; 1 -> out_alt; 2 -> zero-extended/truncated out_pc+8 (mod 2^32); 3 -> all zeros.
REQ-017 SHALL drive fwd_valid = out_valid && out_we && (out_waddr != 0).
REQ-018 SHALL force out_we=0 whenever out_valid=0 (bubble).
REQ-019 flush SHALL take priority over accept and emit in the same cycle: next state EMPTY, in_ready=1, input of that cycle dropped.
REQ-020 out_* payload fields SHALL keep last value when out_valid=0 except out_we.

Reset
REQ-021 reset SHALL force EMPTY, count=0, out_valid=0, out_we=0, fwd_valid=0, in_ready=1 next cycle.
REQ-022 reset SHALL zero out_pc, out_data, out_alt, out_waddr, and skid contents; fwd_data therefore 0.
REQ-023 reset SHALL dominate flush and any handshake in the same cycle, including mid-FULL.

Structure
REQ-024 SHALL place wsel encodings (WSEL_DATA=0, WSEL_ALT=1, WSEL_PC8=2, WSEL_ZERO=3) and state encoding in shared package pipe_pkg.
REQ-025 SHALL implement REQ-016 mux as sub-module wdata_sel, reusable by other stages.
REQ-026 Entry SHALL be one packed field group {pc, data, alt, wsel, waddr, we}.

Verification
REQ-027 Reset, then in_valid=1 one cycle with pc=0x3000, data=0x12, wsel=0 -> next cycle out_valid=1, out_pc=0x3000, fwd_data=0x12.
REQ-028 out_ready=0, push three entries back-to-back -> count 1,2, in_ready=0 after second, third held upstream; release -> order preserved.
REQ-029 wsel=2, pc=0xFFFFFFFC -> fwd_data=0x00000004; wsel=1, alt=0xABCD -> fwd_data=0xABCD.
REQ-030 waddr=0, we=1 -> fwd_valid=0; waddr=5, we=1 -> fwd_valid=1.
REQ-031 FULL, assert flush with in_valid=1 -> next cycle count=0, out_valid=0, in_ready=1, flushed input absent later.
REQ-032 ONE with in_valid=1 and out_ready=1 each cycle for 10 cycles -> count stays 1, one entry per cycle, no drops.
